// File: rtl/uart_fifo_tx_drain.sv
// uart_fifo_tx_drain: FIFO read side feeding a UART transmitter.
// Pops one byte per frame over the rd_en/empty handshake and sends it as
// start + 8 data bits (LSB first) + optional parity + STOP_BITS stop bits.
// Optional even-parity bit: define UART_TX_PARITY_EN.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, waiting for tx_enable with a non-empty FIFO
// REQ    | one-cycle fifo_rd_en pulse
// LOAD   | capture fifo_data (valid the cycle after rd_en)
// START  | start bit, line low
// DATA   | eight data bits, LSB first
// PARITY | even parity over the captured byte (UART_TX_PARITY_EN only)
// STOP   | STOP_BITS stop bits, line high; tx_done on the final cycle
module uart_fifo_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       slow_clk,
  input  logic       rst_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif
  localparam logic [2:0] STOP   = 3'd6;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic bit_end;
  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state, baud counter, bit index and shift register.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_enable && !fifo_empty) state_d = REQ;
      end
      REQ: begin
        // Sole reader: the FIFO cannot drain between IDLE and here.
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        baud_d    = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up with the state they describe (tx_done lands on the last stop cycle).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_idx_d == STOP_LAST);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule
